// File: rtl/bnn_argmax_result.sv
// rtl/bnn_argmax_result.sv - argmax over a streamed frame of BNN class scores
// Emits the winning class index as a one-cycle strobe; wrong-length frames report 4'hF.
module bnn_argmax_result #(
  parameter int NUM_CLASSES = 10,
  parameter int SCORE_W     = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               score_valid,
  output logic               score_ready,
  input  logic [SCORE_W-1:0] score_data,
  input  logic               score_last,
  output logic               result_ready,
  output logic [3:0]         result_out,
  output logic               frame_err,
  output logic               busy
);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_EMIT} state_t;

  localparam logic [3:0] NC     = 4'(NUM_CLASSES);
  localparam logic [4:0] NC_CNT = 5'(NUM_CLASSES);

  state_t             state_q, state_d;
  logic [SCORE_W-1:0] best_score_q, best_score_d;
  logic [3:0]         best_idx_q, best_idx_d;
  logic [3:0]         idx_q, idx_d;
  logic               len_err_q, len_err_d;
  logic [3:0]         result_out_q, result_out_d;
  logic               result_ready_q, result_ready_d;
  logic               frame_err_q, frame_err_d;
  logic               busy_q, busy_d;

  logic               accept;
  logic               err_next;
  logic [4:0]         count;

  assign score_ready = (state_q != S_EMIT);
  assign accept      = score_valid && score_ready;
  assign count       = {1'b0, idx_q} + 5'd1;

  always_comb begin
    state_d        = state_q;
    best_score_d   = best_score_q;
    best_idx_d     = best_idx_q;
    idx_d          = idx_q;
    len_err_d      = len_err_q;
    result_out_d   = result_out_q;
    result_ready_d = 1'b0;
    frame_err_d    = 1'b0;
    err_next       = len_err_q;

    case (state_q)
      S_IDLE, S_ACCUM: begin
        if (clear) begin
          state_d      = S_IDLE;
          idx_d        = 4'd0;
          best_score_d = '0;
          best_idx_d   = 4'd0;
          len_err_d    = 1'b0;
        end else if (accept) begin
          if (state_q == S_IDLE) begin
            best_score_d = score_data;
            best_idx_d   = 4'd0;
            err_next     = 1'b0;
          end else if (idx_q < NC) begin
            if (score_data > best_score_q) begin
              best_score_d = score_data;
              best_idx_d   = idx_q;
            end
          end else begin
            err_next = 1'b1;
          end
          idx_d = (idx_q == 4'd15) ? 4'd15 : idx_q + 4'd1;

          if (score_last) begin
            // count includes this beat; in IDLE idx_q is always 0 so count is 1
            err_next       = err_next || (count != NC_CNT);
            state_d        = S_EMIT;
            result_ready_d = 1'b1;
            frame_err_d    = err_next;
            result_out_d   = err_next ? 4'hF : best_idx_d;
          end else begin
            state_d = S_ACCUM;
          end
          len_err_d = err_next;
        end
      end
      default: begin
        state_d      = S_IDLE;
        len_err_d    = 1'b0;
        idx_d        = 4'd0;
        best_score_d = '0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      best_score_q   <= '0;
      best_idx_q     <= 4'd0;
      idx_q          <= 4'd0;
      len_err_q      <= 1'b0;
      result_out_q   <= 4'd0;
      result_ready_q <= 1'b0;
      frame_err_q    <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      best_score_q   <= best_score_d;
      best_idx_q     <= best_idx_d;
      idx_q          <= idx_d;
      len_err_q      <= len_err_d;
      result_out_q   <= result_out_d;
      result_ready_q <= result_ready_d;
      frame_err_q    <= frame_err_d;
      busy_q         <= busy_d;
    end
  end

  assign result_ready = result_ready_q;
  assign result_out   = result_out_q;
  assign frame_err    = frame_err_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_bnn_argmax_result.sv
// tb/tb_bnn_argmax_result.sv - scoreboard bench for bnn_argmax_result
module tb_bnn_argmax_result;

  localparam int NC = 10;
  localparam int SW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic          score_valid = 1'b0;
  logic          score_ready;
  logic [SW-1:0] score_data = '0;
  logic          score_last = 1'b0;
  logic          result_ready;
  logic [3:0]    result_out;
  logic          frame_err;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int last_cyc = 0;
  int prev_cyc = 0;
  int strobe_cnt = 0;
  int low_cnt = 0;
  logic [4:0] sb[$];

  bnn_argmax_result #(.NUM_CLASSES(NC), .SCORE_W(SW)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .score_valid(score_valid), .score_ready(score_ready),
    .score_data(score_data), .score_last(score_last),
    .result_ready(result_ready), .result_out(result_out),
    .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: strict-greater argmax over the first NC beats, error on any other length.
  function automatic logic [4:0] model(input int s[$]);
    int best = -1;
    int bi = 0;
    for (int i = 0; i < s.size() && i < NC; i++)
      if (s[i] > best) begin best = s[i]; bi = i; end
    if (s.size() != NC) return {1'b1, 4'hF};
    return {1'b0, 4'(bi)};
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (!score_ready) low_cnt++;
      if (result_ready) begin
        logic [4:0] e;
        strobe_cnt++;
        prev_cyc = last_cyc;
        last_cyc = cyc;
        if (sb.size() == 0) chk("unexpected_strobe", 1, 0);
        else begin
          e = sb.pop_front();
          chk("result_out", result_out, e[3:0]);
          chk("frame_err", frame_err, e[4]);
        end
      end else if (frame_err) chk("frame_err_no_strobe", frame_err, 0);
    end
  end

  task automatic wait_accept();
    int n = 0;
    while (!score_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("ready_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic beats(input int s[$], input bit with_last, input bit hold);
    for (int i = 0; i < s.size(); i++) begin
      score_valid = 1'b1;
      score_data  = SW'(s[i]);
      score_last  = with_last && (i == s.size() - 1);
      if (score_last) sb.push_back(model(s));
      wait_accept();
      if (with_last && i == s.size() - 1) chk("latency_strobe", result_ready, 1);
      else if (i == 0) chk("busy_mid_frame", busy, 1);
    end
    score_last = 1'b0;
    if (!hold) score_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("drain_timeout", 0, 1);
  endtask

  initial begin
    int f[$];
    int g[$];
    int s0;
    #1;
    chk("rst_result_out", result_out, 0);
    chk("rst_result_ready", result_ready, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_score_ready", score_ready, 1);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    f = '{3, 9, 4, 1, 0, 2, 5, 20, 6, 8};
    beats(f, 1, 0); drain();
    f = '{1, 3, 12, 5, 0, 11, 12, 2, 7, 4};
    beats(f, 1, 0); drain();
    f = '{5, 2, 7, 30, 1, 9, 4};
    beats(f, 1, 0); drain();
    f = '{5, 2, 7, 30, 1, 9, 4, 8, 6, 3, 10, 50};
    beats(f, 1, 0); drain();
    f = '{77};
    beats(f, 1, 0); drain();

    f = '{1, 2, 3, 40, 5, 6, 7, 8, 9, 10};
    g = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 60};
    low_cnt = 0;
    s0 = strobe_cnt;
    beats(f, 1, 1);
    beats(g, 1, 0);
    drain();
    chk("b2b_strobes", strobe_cnt - s0, 2);
    chk("b2b_spacing", last_cyc - prev_cyc, 11);
    chk("b2b_ready_low", low_cnt, 2);

    s0 = strobe_cnt;
    f = '{4, 4, 4, 4, 4};
    beats(f, 0, 0);
    clear = 1'b1; score_valid = 1'b1; score_data = 8'd99;
    @(negedge clk);
    clear = 1'b0; score_valid = 1'b0;
    chk("clear_busy", busy, 0);
    f = '{5, 30, 2, 1, 0, 7, 3, 9, 8, 6};
    beats(f, 1, 0); drain();
    chk("clear_strobes", strobe_cnt - s0, 1);
    chk("clear_hold_result", result_out, 1);

    s0 = strobe_cnt;
    f = '{9, 8, 7, 6};
    beats(f, 0, 0);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_result_out", result_out, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_ready", result_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    f = '{50, 3, 2, 1, 0, 7, 3, 9, 8, 6};
    beats(f, 1, 0); drain();
    chk("rst_mid_strobes", strobe_cnt - s0, 1);

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/bnn_argmax_result.md
# bnn_argmax_result

Result producer for the OCR datapath: consumes the per-class popcount scores streamed out of the final BNN layer and selects the winning class index. Publishes the index to the seven-segment display driver as a one-cycle `result_ready` strobe with a 4-bit class value. Frames of the wrong length are flagged and reported as class 4'hF, which the display renders as blank.

## Interface

- `NUM_CLASSES`, default 10: beats per valid frame; legal range 2..15.
- `SCORE_W`, default 8: score width; scores are unsigned.

- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `clear`  in  1  synchronous abort of the frame in progress.
- `score_valid`  in  1  score beat valid.
- `score_ready`  out  1  block accepts a beat.
- `score_data`  in  SCORE_W  class score; beat k carries class k.
- `score_last`  in  1  marks the final beat of a frame.
- `result_ready`  out  1  one-cycle strobe; `result_out` is valid.
- `result_out`  out  4  winning class index, or 4'hF on a frame error.
- `frame_err`  out  1  one-cycle strobe, coincident with `result_ready`, on a bad frame length.
- `busy`  out  1  high while a frame is partially received or a result is being emitted.

## Operation

- **States:** IDLE, ACCUM, EMIT.
- **Reset values:**
  - State IDLE.
  - `result_out` = 0.
  - `result_ready`, `frame_err`, `busy` = 0.
  - `best_score` = 0, `best_idx` = 0, beat counter `idx` = 0.
- **`score_ready`:** combinational, equal to (state != EMIT). It is therefore 1 while in reset.
- **Accept:** a beat is accepted on `score_valid && score_ready`.
- **IDLE:**
  - An accepted beat is class 0. It loads `best_score` = `score_data`, `best_idx` = 0, `idx` = 1.
  - Go to ACCUM, or directly to EMIT if `score_last` is set.
- **ACCUM, each accepted beat with `idx < NUM_CLASSES`:**
  - If `score_data > best_score` (strict), load `best_score` and set `best_idx` = `idx`.
  - Ties keep the lower index.
- **Overlong frames:** beats with `idx >= NUM_CLASSES` do not update best. They set the internal sticky `len_err`.
- **`idx` counter:** increments per accepted beat and saturates at 15.
- **Accepted beat with `score_last`:**
  - Go to EMIT.
  - `len_err` is also set if the final count (including this beat) != `NUM_CLASSES`.
- **EMIT (exactly one cycle):**
  - Drive `result_ready` = 1.
  - Drive `result_out` = `len_err ? 4'hF : best_idx`, where `best_idx` includes the last beat's comparison.
  - Drive `frame_err` = `len_err`.
  - Clear `len_err`, `idx`, `best_score`; return to IDLE.
- **`result_out`** is registered and holds its value between strobes.
- **`clear`** in IDLE or ACCUM:
  - Returns to IDLE and zeroes `idx`, `best_*`, `len_err`.
  - Any beat accepted in the same cycle is discarded, because `clear` has priority.
  - No result is emitted.
  - `clear` during EMIT is ignored; the strobe still fires.
- **`busy`:** 1 in ACCUM and EMIT, 0 in IDLE.

## Timing

- **Latency:** the last beat is accepted at edge N; `result_ready`/`result_out` are valid in cycle N+1 for exactly one cycle.
- **Throughput:** one beat per cycle. Back-to-back frames cost one bubble, because `score_ready` = 0 during EMIT.
- **Single-beat frame** (`score_last` on the first beat): for `NUM_CLASSES` ≥ 2 this is always a frame error; emits 4'hF with `frame_err` = 1.
- **Holding off:** `score_valid` may be held high while `score_ready` = 0. The beat is taken on the first cycle after EMIT.
- **Reset mid-frame:** all state is discarded asynchronously. No strobe is produced, and `result_out` returns to 0.

## Test plan

- **Normal frame:** scores {3,9,4,1,0,2,5,20,6,8}, last on beat 9 → `result_ready` one cycle after last, `result_out` = 7, `frame_err` = 0.
- **Tie:** scores with 12 at classes 2 and 6, all others < 12 → `result_out` = 2.
- **Short and long frames:**
  - 7 beats with last on beat 6 → `result_out` = 4'hF, `frame_err` = 1.
  - 12 beats, max 50 at class 11 → 4'hF, `frame_err` = 1.
- **Back-to-back:** two frames (winners 3 then 9) with `score_valid` held high → `score_ready` low for exactly the EMIT cycle; strobes 11 cycles apart; `result_out` 3 then 9.
- **Clear:** `clear` asserted at beat 5 together with a valid beat, then a full frame with winner 1 → exactly one strobe, `result_out` = 1.
- **Reset mid-frame:** `rst_n` pulsed low after 4 beats → `result_out` = 0, `busy` = 0, no strobe; the following full frame (winner 0) emits 0 correctly.
